sia_dispatch: RTL and testbench
===============================

# sia_dispatch

Multi-core work dispatcher between the host work interface and `NCORES` siacore instances. Accepts one 640-bit Blake2b work header plus 64-bit target, gives every core a disjoint nonce start, and collects found nonces through a round-robin arbiter into a result FIFO. After a find, the core is re-issued at the next nonce. A job tag discards results from superseded work.

## Interface
- `NCORES`, 4: number of siacores; power of two, 1..16
- `FIFO_DEPTH`, 8: result FIFO entries; power of two, ≥2
- `JOB_W`, 4: job tag width
- `NONCE_LSB`, 352: LSB of the 32-bit nonce field (header word m04) inside the work vector

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `work_in` in 640: header, byte 0 at [639:632]
- `target_in` in 64: difficulty target, passed to cores unchanged
- `work_valid` in 1: host offers work
- `work_ready` out 1: dispatcher accepts work this cycle
- `core_work` out 640*NCORES: per-core header, core i at [i*640 +: 640]
- `core_target` out 64: shared target
- `core_valid` out NCORES: one-cycle start pulse per core
- `core_busy` in NCORES: core hashing
- `core_found` in NCORES: one-cycle found pulse
- `core_nonce` in 32*NCORES: found nonce, core i at [i*32 +: 32], natural byte order
- `res_nonce` out 32: result nonce, natural byte order
- `res_job` out JOB_W: job tag of the result
- `res_valid` out 1: result available (FIFO not empty)
- `res_ready` in 1: host pops the result
- `job_id` out JOB_W: current job tag

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE: `work_ready`=1. Accepting work moves the block to LOAD.
  - LOAD: lasts exactly 1 cycle, then RUN. `work_ready`=0.
  - RUN: `work_ready`=1. Accepting work moves the block to LOAD.
- Work acceptance when `work_valid && work_ready`:
  - Register `work_in` and `target_in`.
  - Increment `job_id`; it wraps modulo 2^JOB_W.
  - Flush the FIFO.
  - Clear all pending slots.
- LOAD: assert `core_valid` = all ones for one cycle. Core i start nonce is S_i = i·2^32/NCORES.
- Nonce insertion: `core_work[i]` equals the registered work with field [NONCE_LSB +: 32] replaced by the byte-swapped start nonce {s[7:0], s[15:8], s[23:16], s[31:24]}. All other bits are unchanged.
- Find handling: `core_found[i]` high at an edge in RUN captures `core_nonce[i]` into pending slot i.
  - A core's find is ignored if its slot is already occupied. This cannot happen legally.
- Arbiter: round-robin over occupied pending slots. At most one push per cycle, and only when the FIFO is not full.
  - Priority starts at (last grant + 1) mod NCORES. After reset it starts at 0.
- Granted slot i:
  - Push {job_id, nonce} into the FIFO.
  - Free the slot.
  - On the next cycle, pulse `core_valid[i]` with start nonce = nonce + 1 mod 2^32. There is no slice-boundary check.
- FIFO full: pending slots hold and their cores stay idle. Nothing is dropped.
- Pop: `res_valid && res_ready` removes the head. A push and a pop in the same cycle are both allowed when the FIFO is not full.
- Simultaneous new work and `core_found` in the same cycle: the find is discarded, because it belongs to the old job.
- `core_busy` is informational only. `core_valid` is never gated by it.

## Timing
- Reset values:
  - `work_ready`=0 during reset, 1 from the first cycle after `rst` deasserts.
  - `core_valid`=0, `core_work`=0, `core_target`=0.
  - `res_valid`=0, `res_nonce`=0, `res_job`=0.
  - `job_id`=0, state IDLE, FIFO empty, pending cleared, arbiter pointer 0.
- Reset mid-operation returns everything to the reset values above on the next edge. Any in-flight `core_valid` pulse is cut.
- Work accepted at edge E: state is LOAD after E. `core_valid` is high for the cycle after E, sampled by cores at E+1. `job_id` updates at E.
- Find sampled at edge F with no contention and FIFO not full:
  - Slot written at F.
  - Pushed at F+1; `res_valid` high after F+1.
  - Re-issue `core_valid[i]` high after F+1, sampled at F+2.
- N simultaneous finds: pushes happen on N consecutive edges in round-robin order.
- `res_nonce` and `res_job` show the FIFO head combinationally whenever `res_valid`=1.
- The FIFO flush caused by new work takes priority over a same-cycle push or pop.

## Test plan
- Reset, then work with m04 field = 0 and NCORES=4:
  - `core_valid`=4'b1111 one cycle after acceptance.
  - Core nonce fields hold byte-swapped 0x00000000, 0x40000000, 0x80000000, 0xC0000000.
  - `job_id`=1.
- Core 2 found 0x8000_1234:
  - `res_valid` 2 edges later with `res_nonce`=0x80001234 and `res_job`=1.
  - `core_valid[2]` re-pulses with nonce field = swap(0x80001235).
- Cores 0, 1 and 3 find in the same cycle: three results on consecutive cycles in order 0,1,3. Re-issue pulses are staggered the same way.
- FIFO_DEPTH=2 with `res_ready`=0 and three finds:
  - The FIFO fills and `res_valid` stays high.
  - The third find stays pending and that core gets no `core_valid`.
  - Asserting `res_ready` for one cycle drains one entry, then the pending result is pushed.
- New work in the same cycle as a core find:
  - The find is discarded and the FIFO flushes.
  - `job_id` increments.
  - All cores reload. No result carries the old tag.
- `rst` asserted during LOAD and with FIFO non-empty: all outputs are at reset values the next cycle. A subsequent work load starts at `job_id`=1.

Source files
------------

// File: rtl/sia_dispatch_if.sv
//------------------------------------------------------------------------------
// sia_dispatch_if
// Bundles the host work channel, the per-core work/result channel and the
// result FIFO channel of the siacore dispatcher.
//   master : host / core side (drives work, core status and result pop)
//   slave  : dispatcher side (sia_dispatch)
// Signals:
//   work_in[640], target_in[64], work_valid -> work_ready   host work offer
//   core_work[640*NCORES], core_target[64], core_valid[NCORES]  core starts
//   core_busy, core_found[NCORES], core_nonce[32*NCORES]        core status
//   res_nonce[32], res_job[JOB_W], res_valid <- res_ready       result FIFO
//   job_id[JOB_W]                                                current tag
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface sia_dispatch_if #(
    parameter int NCORES = 4,
    parameter int JOB_W  = 4
);
    logic [639:0]          work_in;
    logic [63:0]           target_in;
    logic                  work_valid;
    logic                  work_ready;
    logic [640*NCORES-1:0] core_work;
    logic [63:0]           core_target;
    logic [NCORES-1:0]     core_valid;
    logic [NCORES-1:0]     core_busy;
    logic [NCORES-1:0]     core_found;
    logic [32*NCORES-1:0]  core_nonce;
    logic [31:0]           res_nonce;
    logic [JOB_W-1:0]      res_job;
    logic                  res_valid;
    logic                  res_ready;
    logic [JOB_W-1:0]      job_id;

    modport master (
        output work_in, target_in, work_valid, core_busy, core_found,
               core_nonce, res_ready,
        input  work_ready, core_work, core_target, core_valid, res_nonce,
               res_job, res_valid, job_id
    );

    modport slave (
        input  work_in, target_in, work_valid, core_busy, core_found,
               core_nonce, res_ready,
        output work_ready, core_work, core_target, core_valid, res_nonce,
               res_job, res_valid, job_id
    );
endinterface

// File: rtl/sia_dispatch.sv
//------------------------------------------------------------------------------
// sia_dispatch
// Multi-core work dispatcher. Accepts a 640-bit Blake2b header plus 64-bit
// target from the host, hands every core a disjoint nonce start, collects
// found nonces through a round-robin arbiter into a result FIFO and re-issues
// each finder at the following nonce. A job tag marks results so the host
// can tell which work they belong to; new work flushes everything old.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : sia_dispatch_if.slave (host work, core channel, result FIFO)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sia_dispatch #(
    parameter int NCORES     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int JOB_W      = 4,
    parameter int NONCE_LSB  = 352
) (
    input  logic           clk,
    input  logic           rst,
    sia_dispatch_if.slave  bus
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = JOB_W + 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    // Header nonce field is stored little-endian, cores report natural order.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Start of core i's slice of the 32-bit nonce space.
    function automatic logic [31:0] slice_start(input int i);
        return 32'((64'(i) << 32) / 64'(NCORES));
    endfunction

    function automatic logic [639:0] insert_nonce(input logic [639:0] w,
                                                  input logic [31:0]  s);
        logic [639:0] r;
        r = w;
        r[NONCE_LSB +: 32] = bswap32(s);
        return r;
    endfunction

    logic [1:0]        state;
    logic [639:0]      work_q;
    logic [63:0]       target_q;
    logic [JOB_W-1:0]  job_q;
    logic [31:0]       start_q [NCORES];
    logic [NCORES-1:0] cvalid_q;
    logic [NCORES-1:0] pend_q;
    logic [31:0]       pend_nonce [NCORES];
    logic [IDX_W-1:0]  rr_ptr;
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    logic              work_ready;
    logic              accept;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [NCORES-1:0] cap;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_idx;
    logic [ENT_W-1:0]  head;
    logic              unused_busy;

    // core_busy is status only; starts are never gated by it.
    assign unused_busy = ^bus.core_busy;

    // Ready drops while rst is held so no work slips in during reset.
    assign work_ready = !rst && (state != LOAD);
    assign accept     = bus.work_valid && work_ready;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A find arriving with new work belongs to the old job and is dropped.
    assign cap = (state == RUN && !accept) ? (bus.core_found & ~pend_q) : '0;

    // Round-robin pick among occupied slots, starting at rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        for (int k = 0; k < NCORES; k++) begin
            rr_idx = IDX_W'((int'(rr_ptr) + k) % NCORES);
            if (!gnt_vld && pend_q[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end

    // Flush on new work overrides any same-cycle push or pop.
    assign push = gnt_vld && !fifo_full && !accept;
    assign pop  = !fifo_empty && bus.res_ready && !accept;

    //---------------------------------------------------------------- control
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work_q   <= '0;
            target_q <= '0;
            job_q    <= '0;
            cvalid_q <= '0;
            pend_q   <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < NCORES; i++) begin
                start_q[i] <= '0;
            end
        end else begin
            cvalid_q <= '0;

            case (state)
                IDLE:    if (accept) state <= LOAD;
                LOAD:    state <= RUN;
                RUN:     if (accept) state <= LOAD;
                default: state <= IDLE;
            endcase

            if (accept) begin
                work_q   <= bus.work_in;
                target_q <= bus.target_in;
                job_q    <= job_q + JOB_W'(1);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                pend_q   <= '0;
                cvalid_q <= '1;
                for (int i = 0; i < NCORES; i++) begin
                    start_q[i] <= slice_start(i);
                end
            end else begin
                for (int i = 0; i < NCORES; i++) begin
                    if (cap[i]) pend_q[i] <= 1'b1;
                end
                if (push) begin
                    // Capture and grant never hit the same slot: capture
                    // requires the slot empty, grant requires it occupied.
                    pend_q[gnt_idx]   <= 1'b0;
                    wr_ptr            <= wr_ptr + (AW+1)'(1);
                    rr_ptr            <= IDX_W'((int'(gnt_idx) + 1) % NCORES);
                    cvalid_q[gnt_idx] <= 1'b1;
                    start_q[gnt_idx]  <= pend_nonce[gnt_idx] + 32'd1;
                end
                if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    //------------------------------------------------------------------- data
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORES; i++) begin
            if (cap[i]) pend_nonce[i] <= bus.core_nonce[i*32 +: 32];
        end
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {job_q, pend_nonce[gnt_idx]};
    end

    //---------------------------------------------------------------- outputs
    always_comb begin
        bus.core_work = '0;
        for (int i = 0; i < NCORES; i++) begin
            bus.core_work[i*640 +: 640] = insert_nonce(work_q, start_q[i]);
        end
    end

    // Head is masked while empty so outputs read zero after reset/flush.
    assign head           = fifo_mem[rd_ptr[AW-1:0]];
    assign bus.res_valid  = !fifo_empty;
    assign bus.res_nonce  = fifo_empty ? 32'd0 : head[31:0];
    assign bus.res_job    = fifo_empty ? JOB_W'(0) : head[ENT_W-1:32];
    assign bus.work_ready = work_ready;
    assign bus.core_target = target_q;
    assign bus.core_valid = cvalid_q;
    assign bus.job_id     = job_q;

endmodule

// File: tb/tb_sia_dispatch.sv
//------------------------------------------------------------------------------
// tb_sia_dispatch
// Scoreboard bench for sia_dispatch (NCORES=4, FIFO_DEPTH=2). Expected
// results are queued when finds are driven and compared as the FIFO pops.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sia_dispatch;

    localparam int NCORES     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int JOB_W      = 4;
    localparam int NONCE_LSB  = 352;
    localparam logic [63:0] TGT = 64'h0000_00FF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sia_dispatch_if #(.NCORES(NCORES), .JOB_W(JOB_W)) bus ();

    sia_dispatch #(
        .NCORES(NCORES), .FIFO_DEPTH(FIFO_DEPTH),
        .JOB_W(JOB_W), .NONCE_LSB(NONCE_LSB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int nvec = 0;
    int nmis = 0;
    logic [35:0]  sb [$];
    logic [639:0] w1, w2, w3;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [31:0] field(input int i);
        return bus.core_work[i*640 + NONCE_LSB +: 32];
    endfunction

    // Everything outside the nonce field must equal the host header.
    function automatic logic others_ok(input int i, input logic [639:0] w);
        logic [639:0] got;
        logic [639:0] exp;
        got = bus.core_work[i*640 +: 640];
        exp = w;
        got[NONCE_LSB +: 32] = '0;
        exp[NONCE_LSB +: 32] = '0;
        return got == exp;
    endfunction

    function automatic logic [639:0] rand_work();
        logic [639:0] w;
        for (int k = 0; k < 20; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic load(input logic [639:0] w);
        bus.work_in    = w;
        bus.target_in  = TGT;
        bus.work_valid = 1'b1;
        tick();
        bus.work_valid = 1'b0;
    endtask

    task automatic chk_load(input logic [639:0] w, input logic [JOB_W-1:0] job);
        logic [31:0] s;
        check("ld_cvalid", 64'(bus.core_valid), 64'hF);
        check("ld_job", 64'(bus.job_id), 64'(job));
        check("ld_ready", 64'(bus.work_ready), 64'd0);
        check("ld_target", bus.core_target, TGT);
        for (int i = 0; i < NCORES; i++) begin
            s = 32'(i) * 32'h4000_0000;
            check("ld_nonce", 64'(field(i)), 64'(bswap(s)));
            check("ld_other", 64'(others_ok(i, w)), 64'd1);
        end
    endtask

    task automatic chk_reset();
        check("rst_ready", 64'(bus.work_ready), 64'd0);
        check("rst_cvalid", 64'(bus.core_valid), 64'd0);
        check("rst_work", 64'(bus.core_work == '0), 64'd1);
        check("rst_target", bus.core_target, 64'd0);
        check("rst_rvalid", 64'(bus.res_valid), 64'd0);
        check("rst_rnonce", 64'(bus.res_nonce), 64'd0);
        check("rst_rjob", 64'(bus.res_job), 64'd0);
        check("rst_job", 64'(bus.job_id), 64'd0);
    endtask

    task automatic find(input logic [3:0] mask, input logic [31:0] n0,
                        input logic [31:0] n1, input logic [31:0] n2,
                        input logic [31:0] n3);
        bus.core_found = mask;
        bus.core_nonce = {n3, n2, n1, n0};
        tick();
        bus.core_found = '0;
    endtask

    // Result monitor: a pop happens at the next edge unless reset or flush.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready &&
            !(bus.work_valid && bus.work_ready)) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 64'(bus.res_valid), 64'd0);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                check("res_nonce", 64'(bus.res_nonce), 64'(e[31:0]));
                check("res_job", 64'(bus.res_job), 64'(e[35:32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.work_in    = '0;
        bus.target_in  = '0;
        bus.work_valid = 1'b0;
        bus.core_busy  = '0;
        bus.core_found = '0;
        bus.core_nonce = '0;
        bus.res_ready  = 1'b1;
        w1 = rand_work();
        w1[NONCE_LSB +: 32] = '0;
        w2 = rand_work();
        w3 = rand_work();

        tick();
        tick();
        chk_reset();
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(bus.work_ready), 64'd1);

        // First work: every core gets its quarter of the nonce space.
        load(w1);
        chk_load(w1, JOB_W'(1));
        tick();
        check("run_cvalid", 64'(bus.core_valid), 64'd0);
        check("run_ready", 64'(bus.work_ready), 64'd1);

        // Cores 0,1,3 find together; pointer is 0, so order 0,1,3.
        sb.push_back({4'd1, 32'h0000_0AAA});
        sb.push_back({4'd1, 32'h4000_0BBB});
        sb.push_back({4'd1, 32'hC000_0CCC});
        find(4'b1011, 32'h0000_0AAA, 32'h4000_0BBB, 32'h0, 32'hC000_0CCC);
        check("m_cvalid0", 64'(bus.core_valid), 64'd0);
        check("m_rvalid0", 64'(bus.res_valid), 64'd0);
        tick();
        check("m_cvalid1", 64'(bus.core_valid), 64'b0001);
        check("m_reissue0", 64'(field(0)), 64'(bswap(32'h0000_0AAB)));
        tick();
        check("m_cvalid2", 64'(bus.core_valid), 64'b0010);
        check("m_reissue1", 64'(field(1)), 64'(bswap(32'h4000_0BBC)));
        tick();
        check("m_cvalid3", 64'(bus.core_valid), 64'b1000);
        check("m_reissue3", 64'(field(3)), 64'(bswap(32'hC000_0CCD)));
        tick();
        check("m_cvalid4", 64'(bus.core_valid), 64'd0);

        // Single find on core 2.
        sb.push_back({4'd1, 32'h8000_1234});
        find(4'b0100, 32'h0, 32'h0, 32'h8000_1234, 32'h0);
        check("s_rvalid0", 64'(bus.res_valid), 64'd0);
        check("s_cvalid0", 64'(bus.core_valid), 64'd0);
        tick();
        check("s_rvalid1", 64'(bus.res_valid), 64'd1);
        check("s_rnonce", 64'(bus.res_nonce), 64'h8000_1234);
        check("s_cvalid1", 64'(bus.core_valid), 64'b0100);
        check("s_reissue2", 64'(field(2)), 64'(bswap(32'h8000_1235)));
        tick();
        check("s_cvalid2", 64'(bus.core_valid), 64'd0);

        // FIFO full: pointer is 3, finds on 0,1,2; core 2 must wait.
        bus.res_ready = 1'b0;
        sb.push_back({4'd1, 32'h0000_0011});
        sb.push_back({4'd1, 32'h4000_0022});
        sb.push_back({4'd1, 32'h8000_0033});
        find(4'b0111, 32'h0000_0011, 32'h4000_0022, 32'h8000_0033, 32'h0);
        tick();
        check("f_cvalid1", 64'(bus.core_valid), 64'b0001);
        tick();
        check("f_cvalid2", 64'(bus.core_valid), 64'b0010);
        tick();
        check("f_cvalid3", 64'(bus.core_valid), 64'd0);
        check("f_rvalid", 64'(bus.res_valid), 64'd1);
        tick();
        check("f_cvalid4", 64'(bus.core_valid), 64'd0);
        check("f_head", 64'(bus.res_nonce), 64'h0000_0011);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("f_cvalid5", 64'(bus.core_valid), 64'd0);
        check("f_head2", 64'(bus.res_nonce), 64'h4000_0022);
        tick();
        check("f_cvalid6", 64'(bus.core_valid), 64'b0100);
        check("f_reissue2", 64'(field(2)), 64'(bswap(32'h8000_0034)));
        bus.res_ready = 1'b1;
        tick();
        tick();
        tick();
        check("f_drained", 64'(bus.res_valid), 64'd0);

        // New work in the same cycle as a find: find dropped, all reload.
        bus.work_in    = w2;
        bus.target_in  = TGT;
        bus.work_valid = 1'b1;
        bus.core_found = 4'b0010;
        bus.core_nonce = {32'h0, 32'h0, 32'h4000_5555, 32'h0};
        tick();
        bus.work_valid = 1'b0;
        bus.core_found = '0;
        chk_load(w2, JOB_W'(2));
        check("nw_rvalid0", 64'(bus.res_valid), 64'd0);
        tick();
        check("nw_cvalid1", 64'(bus.core_valid), 64'd0);
        tick();
        tick();
        check("nw_cvalid2", 64'(bus.core_valid), 64'd0);
        check("nw_rvalid1", 64'(bus.res_valid), 64'd0);

        // Reset with a result sitting in the FIFO.
        bus.res_ready = 1'b0;
        find(4'b1000, 32'h0, 32'h0, 32'h0, 32'hC000_0001);
        tick();
        check("r_rvalid", 64'(bus.res_valid), 64'd1);
        check("r_rjob", 64'(bus.res_job), 64'd2);
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        tick();

        // Reset during LOAD cuts the start pulse.
        load(w3);
        chk_load(w3, JOB_W'(1));
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        tick();
        load(w3);
        chk_load(w3, JOB_W'(1));
        tick();

        // A result after reset carries the fresh tag.
        bus.res_ready = 1'b1;
        sb.push_back({4'd1, 32'h4000_0042});
        find(4'b0010, 32'h0, 32'h4000_0042, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
